// File: rtl/conv1d_multi_kernel.sv
// Streaming 1-D convolution layer: NUM_KERNELS runtime-loaded kernels
// plus bias, applied with one shared MAC, with optional ReLU.
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   start_i                   begin a frame (taken in IDLE only)
//   data_i, valid_i, ready_o  input sample stream (FIFO pop side)
//   wvalid_i, wdata_i         weight/bias load port (taken in IDLE only)
//   data_o, valid_o, ready_i  result stream to the next layer
//   last_o                    marks the final result of a frame
module conv1d_multi_kernel #(
  parameter int WORD_SIZE          = 16,
  parameter int INT_BITS           = 4,
  parameter int INPUT_LAYER_HEIGHT = 128,
  parameter int KERNEL_HEIGHT      = 16,
  parameter int NUM_KERNELS        = 4,
  parameter int STRIDE             = 1,
  parameter int RELU               = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 wvalid_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o
);

  localparam int FRAC = WORD_SIZE - INT_BITS;
  localparam int NW   = NUM_KERNELS * (KERNEL_HEIGHT + 1);
  localparam int NPOS =
    (INPUT_LAYER_HEIGHT - KERNEL_HEIGHT) / STRIDE + 1;
  localparam int AW   =
    2 * WORD_SIZE + $clog2(KERNEL_HEIGHT + 1);
  localparam int TW   = $clog2(KERNEL_HEIGHT + 1);
  localparam int IW   = $clog2(KERNEL_HEIGHT);
  localparam int WPW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int KW   =
    (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam int PW   = (NPOS > 1) ? $clog2(NPOS) : 1;

  localparam logic signed [AW-1:0] SMAX =
    AW'((64'sd1 <<< (WORD_SIZE - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_MAC,
    S_OUT,
    S_SHIFT
  } state_t;

  state_t state_q, state_d;

  logic signed [WORD_SIZE-1:0] wmem [NW];
  logic signed [WORD_SIZE-1:0] win_q [KERNEL_HEIGHT];

  logic [TW-1:0]  pcnt_q;
  logic [TW-1:0]  tap_q;
  logic [KW-1:0]  k_q;
  logic [PW-1:0]  pos_q;
  logic [WPW-1:0] wptr_q;

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] bias_sh, prod_x, res;
  logic signed [2*WORD_SIZE-1:0] prod;
  logic [WORD_SIZE-1:0] sat;

  logic [IW-1:0]  tsel;
  logic [WPW-1:0] widx, bidx;

  logic pop, pend, mac_end;
  logic last_k, last_p, wlast, wr_en;

  assign last_k  = (k_q == KW'(NUM_KERNELS - 1));
  assign last_p  = (pos_q == PW'(NPOS - 1));
  assign mac_end = (tap_q == TW'(KERNEL_HEIGHT));
  assign wlast   = (wptr_q == WPW'(NW - 1));

  // FILL ends after a full window, SHIFT after STRIDE pops
  assign pend = (state_q == S_FILL)
              ? (pcnt_q == TW'(KERNEL_HEIGHT - 1))
              : (pcnt_q == TW'(STRIDE - 1));

  // start wins over a simultaneous weight word
  assign wr_en = (state_q == S_IDLE) && wvalid_i
              && !start_i && !reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FILL;
      end
      S_FILL: begin
        ready_o = 1'b1;
        if (valid_i && pend) state_d = S_MAC;
      end
      S_MAC: begin
        if (mac_end) state_d = S_OUT;
      end
      S_OUT: begin
        valid_o = 1'b1;
        last_o  = last_k && last_p;
        if (ready_i) begin
          if (!last_k)     state_d = S_MAC;
          else if (last_p) state_d = S_IDLE;
          else             state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ready_o = 1'b1;
        if (valid_i && pend) state_d = S_MAC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop = ready_o & valid_i;

  // weights and bias keep their contents across reset
  always_ff @(posedge clk_i) begin
    if (wr_en) wmem[wptr_q] <= wdata_i;
  end

  // newest sample enters the top of the window
  always_ff @(posedge clk_i) begin
    if (pop) begin
      for (int j = 0; j < KERNEL_HEIGHT - 1; j++)
        win_q[j] <= win_q[j+1];
      win_q[KERNEL_HEIGHT-1] <= data_i;
    end
  end

  // tap index is out of range on the final MAC cycle
  assign tsel = mac_end ? '0 : IW'(tap_q);
  assign widx = WPW'(int'(k_q) * (KERNEL_HEIGHT + 1)
              + int'(tap_q));
  assign bidx = WPW'(int'(k_q) * (KERNEL_HEIGHT + 1)
              + KERNEL_HEIGHT);

  assign prod    = win_q[tsel] * wmem[widx];
  assign prod_x  = AW'(prod);
  assign bias_sh = AW'(wmem[bidx]) <<< FRAC;

  // first tap seeds the accumulator with the aligned bias
  assign acc_d = (tap_q == '0) ? bias_sh + prod_x
                               : acc_q + prod_x;

  always_comb begin
    res = acc_q >>> FRAC;
    sat = res[WORD_SIZE-1:0];
    unique case (1'b1)
      (res > SMAX): sat = SMAX[WORD_SIZE-1:0];
      (res < SMIN): sat = SMIN[WORD_SIZE-1:0];
      default: ;
    endcase
    if (RELU != 0 && sat[WORD_SIZE-1]) sat = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pcnt_q <= '0;
      tap_q  <= '0;
      k_q    <= '0;
      pos_q  <= '0;
      wptr_q <= '0;
      acc_q  <= '0;
      data_o <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            pcnt_q <= '0;
            tap_q  <= '0;
            k_q    <= '0;
            pos_q  <= '0;
          end else if (wvalid_i) begin
            wptr_q <= wlast ? '0 : wptr_q + 1'b1;
          end
        end
        S_FILL, S_SHIFT: begin
          if (pop) pcnt_q <= pend ? '0 : pcnt_q + 1'b1;
        end
        S_MAC: begin
          if (mac_end) begin
            tap_q  <= '0;
            data_o <= sat;
          end else begin
            tap_q <= tap_q + 1'b1;
            acc_q <= acc_d;
          end
        end
        S_OUT: begin
          if (ready_i) begin
            if (last_k) begin
              k_q <= '0;
              if (!last_p) pos_q <= pos_q + 1'b1;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_multi_kernel.sv
// Bench for conv1d_multi_kernel: three lanes (stride 1 ReLU,
// stride 2 ReLU, stride 1 no ReLU) driven from one sample source.
module tb_conv1d_multi_kernel;

  localparam int KH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, wvalid;
  logic [15:0] wdata;
  logic [15:0] din [3];
  logic [15:0] dout [3];
  logic        vin [3];
  logic        rdyo [3];
  logic        vout [3];
  logic        rin [3];
  logic        lst [3];

  logic [15:0] src [8];
  logic [15:0] wtab [8];
  logic        src_en, clr, stall, bp_hold;

  int          idx [3];
  int          ocnt [3];
  logic [15:0] oq [3][16];
  logic        lq [3][16];
  logic        done [3];
  int          cyc = 0;
  int          fill_cyc, fv_cyc;
  int          errs = 0;
  int          checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    conv1d_multi_kernel #(
      .WORD_SIZE(16),
      .INT_BITS(4),
      .INPUT_LAYER_HEIGHT(8),
      .KERNEL_HEIGHT(KH),
      .NUM_KERNELS(2),
      .STRIDE((g == 1) ? 2 : 1),
      .RELU((g == 2) ? 0 : 1)
    ) u_dut (
      .clk_i(clk),
      .reset_i(rst),
      .start_i(start),
      .data_i(din[g]),
      .valid_i(vin[g]),
      .ready_o(rdyo[g]),
      .wvalid_i(wvalid),
      .wdata_i(wdata),
      .data_o(dout[g]),
      .valid_o(vout[g]),
      .ready_i(rin[g]),
      .last_o(lst[g])
    );
    assign vin[g] = src_en && !stall && (idx[g] < 8);
    assign din[g] = src[idx[g] % 8];
    assign rin[g] = !((g == 0) && bp_hold);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 3; g++) begin
      if (clr) begin
        idx[g]  <= 0;
        ocnt[g] <= 0;
        done[g] <= 1'b0;
      end else begin
        if (vin[g] && rdyo[g]) idx[g] <= idx[g] + 1;
        if (vout[g] && rin[g]) begin
          if (ocnt[g] < 16) begin
            oq[g][ocnt[g]] <= dout[g];
            lq[g][ocnt[g]] <= lst[g];
          end
          ocnt[g] <= ocnt[g] + 1;
          if (lst[g]) done[g] <= 1'b1;
        end
      end
    end
    if (clr) begin
      fill_cyc <= -1;
      fv_cyc   <= -1;
    end else begin
      if (vin[0] && rdyo[0] && idx[0] == 2 && fill_cyc < 0)
        fill_cyc <= cyc;
      if (vout[0] && fv_cyc < 0) fv_cyc <= cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wvalid = 1'b1;
      wdata  = wtab[i];
    end
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic set_basic_w();
    wtab = '{16'h0000, 16'h0000, 16'h1000, 16'h0000,
             16'h1000, 16'h1000, 16'h1000, 16'h0800};
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 8; i++) src[i] = 16'(16'h0400 * (i + 1));
  endtask

  task automatic run(input bit bp, input bit starve,
                     input bit glitch);
    int t, stl, stl_idx, bpn, bpi;
    bit s1, s2, bpa, bpd;
    logic [15:0] cap;
    @(negedge clk);
    clr = 1'b1; stall = 1'b0; bp_hold = bp; src_en = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    start = 1'b1;
    if (glitch) begin wvalid = 1'b1; wdata = 16'h7FFF; end
    @(negedge clk);
    start = 1'b0; wvalid = 1'b0;
    t = 0; stl = 0; stl_idx = 0; s1 = 0; s2 = 0;
    bpa = 0; bpd = 0; bpn = 0; bpi = 0; cap = '0;
    while (!(done[0] && done[1] && done[2]) && t < 2000) begin
      if (glitch && t == 15) begin
        wvalid = 1'b1; wdata = 16'h7FFF;
      end else begin
        wvalid = 1'b0;
      end
      if (starve) begin
        if (stl > 0) begin
          stl--;
          if (stl == 0) begin
            stall = 1'b0;
            chk("starve_nopop", idx[0], stl_idx);
          end
        end else if (!s1 && idx[0] == 1) begin
          s1 = 1; stall = 1'b1; stl = 5; stl_idx = idx[0];
        end else if (!s2 && idx[0] == 4 && rdyo[0]) begin
          s2 = 1; stall = 1'b1; stl = 5; stl_idx = idx[0];
        end
      end
      if (bp && !bpd) begin
        if (!bpa && vout[0]) begin
          bpa = 1; cap = dout[0]; bpi = idx[0];
        end else if (bpa) begin
          chk("bp_valid", vout[0], 1);
          chk("bp_data", dout[0], cap);
          chk("bp_nopop", idx[0], bpi);
          chk("bp_noxfer", ocnt[0], 0);
          bpn++;
          if (bpn == 10) begin bp_hold = 1'b0; bpd = 1; end
        end
      end
      @(negedge clk);
      t++;
    end
    chk("run_timeout", t < 2000, 1);
    if (bp) chk("bp_seen", bpd, 1);
    if (starve) chk("starve_seen", s1 && s2, 1);
    src_en = 1'b0; wvalid = 1'b0; bp_hold = 1'b0; stall = 1'b0;
  endtask

  task automatic check_basic(input string tag);
    for (int g = 0; g < 3; g++) begin
      int n;
      n = (g == 1) ? 6 : 12;
      chk($sformatf("%s_cnt%0d", tag, g), ocnt[g], n);
      for (int i = 0; i < n; i++) begin
        int s;
        logic [15:0] e;
        s = (g == 1) ? 2 * (i / 2) : i / 2;
        if (i % 2 == 0) e = 16'(16'h0400 * (s + 3));
        else e = 16'(16'h0400 * (3 * s + 6) + 16'h0800);
        chk($sformatf("%s_d%0d_%0d", tag, g, i), oq[g][i], e);
        chk($sformatf("%s_l%0d_%0d", tag, g, i),
            lq[g][i], (i == n - 1));
      end
    end
    chk({tag, "_k0first"}, oq[0][0], 16'h0C00);
    chk({tag, "_k1first"}, oq[0][1], 16'h2000);
    chk({tag, "_k1last"}, oq[0][11], 16'h5C00);
    chk({tag, "_s2k0b"}, oq[1][2], 16'h1400);
    chk({tag, "_s2k0c"}, oq[1][4], 16'h1C00);
    chk({tag, "_pops0"}, idx[0], 8);
    chk({tag, "_pops1"}, idx[1], 7);
  endtask

  task automatic check_all(input string tag, input int g,
                           input int n, input logic [15:0] e);
    chk($sformatf("%s_cnt%0d", tag, g), ocnt[g], n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_d%0d_%0d", tag, g, i), oq[g][i], e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; wvalid = 1'b0; wdata = '0;
    src_en = 1'b0; clr = 1'b1; stall = 1'b0; bp_hold = 1'b0;
    set_ramp();
    repeat (3) @(negedge clk);
    rst = 1'b0; clr = 1'b0;
    chk("rst_ready", rdyo[0], 0);
    chk("rst_valid", vout[0], 0);
    chk("rst_last", lst[0], 0);
    chk("rst_data", dout[0], 16'h0000);

    set_basic_w();
    load();
    run(0, 0, 0);
    check_basic("basic");
    chk("latency", fv_cyc - fill_cyc, KH + 2);

    run(1, 1, 1);
    check_basic("stress");

    wtab = '{16'h1000, 16'h1000, 16'h1000, 16'h0000,
             16'h1000, 16'h1000, 16'h1000, 16'h0000};
    load();
    for (int i = 0; i < 8; i++) src[i] = 16'h7000;
    run(0, 0, 0);
    check_all("satp", 0, 12, 16'h7FFF);
    check_all("satp", 1, 6, 16'h7FFF);
    check_all("satp", 2, 12, 16'h7FFF);
    for (int i = 0; i < 8; i++) src[i] = 16'h9000;
    run(0, 0, 0);
    check_all("satn", 0, 12, 16'h0000);
    check_all("satn", 1, 6, 16'h0000);
    check_all("satn", 2, 12, 16'h8000);

    set_basic_w();
    load();
    set_ramp();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; src_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (fill_cyc < 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rmac_timeout", t < 100, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmac_ready", rdyo[0], 0);
    chk("rmac_valid", vout[0], 0);
    chk("rmac_data", dout[0], 16'h0000);
    repeat (20) @(negedge clk);
    chk("rmac_nostale", ocnt[0], 0);
    chk("rmac_idle", rdyo[0], 0);
    src_en = 1'b0;
    run(0, 0, 0);
    check_basic("rerun");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
